cpu_step_ctrl: RTL

Execution controller for the 16-bit `integration` CPU on the board build. It turns a raw push-button and a run switch into a clock-enable (`cpu_en`) for the CPU, using single-step, free-run and breakpoint-halt modes. It also snapshots the CPU bus after every executed cycle, giving the hex displays a stable value, and keeps a wrapping count of executed cycles. It sits between the board inputs (KEY/SW) and the CPU/display path in `top_level`.

---
 rtl/cpu_step_if.sv | 27 ++
 rtl/cpu_step_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cpu_step_if.sv
// CPU-side and display-side signals of the execution controller.
// The controller holds the slave modport; the CPU/display path holds master.
interface cpu_step_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] bus_in;
    logic              cpu_en;
    logic [1:0]        state;
    logic [DATA_W-1:0] disp_value;
    logic [15:0]       cycle_count;

    modport slave (
        input  bus_in,
        output cpu_en,
        output state,
        output disp_value,
        output cycle_count
    );

    modport master (
        output bus_in,
        input  cpu_en,
        input  state,
        input  disp_value,
        input  cycle_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Step/run/breakpoint clock-enable controller for the board CPU,
// with a bus snapshot for the displays and an executed-cycle counter.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 4,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_key,
    input  logic              run_sw,
    input  logic              bp_en,
    input  logic [DATA_W-1:0] bp_value,
    cpu_step_if.slave         cif
);

    localparam int DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W  = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_STEP  = 2'b01,
        S_RUN   = 2'b10,
        S_BREAK = 2'b11
    } state_e;

    logic              key_m_q, key_m_d;
    logic              key_s_q, key_s_d;
    logic              run_m_q, run_m_d;
    logic              run_s_q, run_s_d;
    logic              db_q, db_d;
    logic              db_last_q, db_last_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              step_pulse_q, step_pulse_d;
    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              en_d_q, en_d_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [15:0]       count_q, count_d;

    logic              cpu_en;
    logic              bp_hit;

    // Two-flop synchronizers for the asynchronous board inputs
    always_comb begin
        key_m_d = step_key;
        key_s_d = key_m_q;
        run_m_d = run_sw;
        run_s_d = run_m_q;
    end

    always_comb begin
        db_d   = db_q;
        dcnt_d = '0;
        if (key_s_q != db_q) begin
            if (dcnt_q == DCNT_MAX) begin
                db_d   = key_s_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Press edge only; releasing the key yields nothing
    always_comb begin
        db_last_d    = db_q;
        step_pulse_d = db_last_q & ~db_q;
    end

    assign cpu_en = (state_q == S_STEP) ||
                    ((state_q == S_RUN) && (div_cnt_q == DIV_MAX));

    assign bp_hit = (state_q == S_RUN) && en_d_q && bp_en &&
                    (cif.bus_in == bp_value);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_s_q) begin
                    state_d = S_RUN;
                end else if (step_pulse_q) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (bp_hit) begin
                    state_d = S_BREAK;
                end else if (!run_s_q) begin
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                if (!run_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Divider restarts from zero on every RUN entry
    always_comb begin
        div_cnt_d = '0;
        if (state_q == S_RUN) begin
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Capture one cycle after the enable, once the CPU bus has settled
    always_comb begin
        en_d_d  = cpu_en;
        disp_d  = disp_q;
        count_d = count_q;
        if (en_d_q) begin
            disp_d  = cif.bus_in;
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_m_q      <= 1'b1;
            key_s_q      <= 1'b1;
            run_m_q      <= 1'b0;
            run_s_q      <= 1'b0;
            db_q         <= 1'b1;
            db_last_q    <= 1'b1;
            dcnt_q       <= '0;
            step_pulse_q <= 1'b0;
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            en_d_q       <= 1'b0;
            disp_q       <= '0;
            count_q      <= '0;
        end else begin
            key_m_q      <= key_m_d;
            key_s_q      <= key_s_d;
            run_m_q      <= run_m_d;
            run_s_q      <= run_s_d;
            db_q         <= db_d;
            db_last_q    <= db_last_d;
            dcnt_q       <= dcnt_d;
            step_pulse_q <= step_pulse_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            en_d_q       <= en_d_d;
            disp_q       <= disp_d;
            count_q      <= count_d;
        end
    end

    assign cif.cpu_en      = cpu_en;
    assign cif.state       = state_q;
    assign cif.disp_value  = disp_q;
    assign cif.cycle_count = count_q;

endmodule
